// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if
//   Bus bundle between the AHB switch slave port and the SRAM target.
//   Signals (switch -> target): S_ADDRESS, S_CHIP_SELECT, S_BYTE_ENABLE,
//   S_WRITE, S_WDATA, S_TRANS.
//   Signals (target -> switch): S_RDATA, S_RESP, S_READY.
//   modport master: switch side; modport slave: SRAM target side.
interface ahb_sram_slave_if;
  logic [31:0] S_ADDRESS;
  logic        S_CHIP_SELECT;
  logic [3:0]  S_BYTE_ENABLE;
  logic        S_WRITE;
  logic [31:0] S_WDATA;
  logic [1:0]  S_TRANS;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RESP;
  logic        S_READY;

  modport master (
    output S_ADDRESS, S_CHIP_SELECT, S_BYTE_ENABLE, S_WRITE, S_WDATA, S_TRANS,
    input  S_RDATA, S_RESP, S_READY
  );

  modport slave (
    input  S_ADDRESS, S_CHIP_SELECT, S_BYTE_ENABLE, S_WRITE, S_WDATA, S_TRANS,
    output S_RDATA, S_RESP, S_READY
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   Word-organised SRAM target on one AHB switch slave port. Accepts
//   pipelined address phases, inserts WAIT_STATES wait cycles per OKAY data
//   phase, applies byte-lane writes, returns read data and produces the
//   two-cycle ERROR response for word indices >= DEPTH.
//   Ports:
//     HCLOCK   - system clock, rising edge
//     HRESETn  - asynchronous active-low reset
//     bus      - ahb_sram_slave_if.slave (S_* address/data/response signals)
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no data phase pending, READY=1, OKAY
//   WAIT  | OKAY data phase stalled, READY=0, counter running
//   DATA  | final OKAY data phase cycle, read data out / write commits
//   ERR1  | first ERROR cycle, READY=0, RESP=ERROR
//   ERR2  | second ERROR cycle, READY=1, RESP=ERROR
module ahb_sram_slave #(
  parameter int unsigned DEPTH       = 16384,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              HCLOCK,
  input  logic              HRESETn,
  ahb_sram_slave_if.slave   bus
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [26:0] DEPTH_W   = 27'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      be_q, be_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH];

  logic [25:0]     addr_idx;
  logic            addr_err;
  logic            ready;
  logic [1:0]      resp;
  logic            accept;
  logic            mem_we;
  logic            unused_addr_bits;

  assign addr_idx = bus.S_ADDRESS[27:2];
  assign addr_err = {1'b0, addr_idx} >= DEPTH_W;

  // Bits above the word index, the byte offset and HTRANS[0] carry no
  // meaning for a word SRAM; upper index bits only feed the range check.
  assign unused_addr_bits = ^{bus.S_ADDRESS[31:28], bus.S_ADDRESS[1:0],
                              bus.S_TRANS[0], addr_idx};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wr_d    = wr_q;
    err_d   = err_q;
    ready   = 1'b1;
    resp    = RESP_OKAY;

    unique case (state_q)
      ST_WAIT: ready = 1'b0;
      ST_ERR1: begin
        ready = 1'b0;
        resp  = RESP_ERR;
      end
      ST_ERR2: resp = RESP_ERR;
      default: ;
    endcase

    accept = ready && bus.S_CHIP_SELECT && bus.S_TRANS[1];

    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // A new address phase overrides the default successor of IDLE, DATA
    // and ERR2; WAIT and ERR1 never reach here because ready is low.
    if (accept) begin
      idx_d = addr_idx[AW-1:0];
      be_d  = bus.S_BYTE_ENABLE;
      wr_d  = bus.S_WRITE;
      err_d = addr_err;
      if (addr_err) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_INIT;
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  always_ff @(posedge HCLOCK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Memory is not reset. A reset forces state_q to IDLE, which blocks any
  // pending write from committing.
  assign mem_we = (state_q == ST_DATA) && wr_q && !err_q;

  always_ff @(posedge HCLOCK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= bus.S_WDATA[8*b +: 8];
      end
    end
  end

  assign bus.S_READY = ready;
  assign bus.S_RESP  = resp;
  assign bus.S_RDATA = ((state_q == ST_DATA) && !wr_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
//   Three targets (DEPTH=1024; WAIT_STATES 0, 3, 5) share one set of driven
//   inputs; sel picks whose outputs the master model follows. Expected
//   transfer results are queued as each address phase is accepted and
//   compared against the observed data phases.
module tb_ahb_sram_slave;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          low;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [1:0]  first_resp;
    int          low;
  } obs_t;

  logic        HCLOCK;
  logic        HRESETn;
  logic [31:0] t_addr;
  logic        t_cs;
  logic [3:0]  t_be;
  logic        t_wr;
  logic [31:0] t_wdata;
  logic [1:0]  t_trans;

  logic        rdy_a   [3];
  logic [1:0]  resp_a  [3];
  logic [31:0] rdata_a [3];
  logic [1:0]  sel;
  logic        o_rdy;
  logic [1:0]  o_resp;
  logic [31:0] o_rdata;

  xfer_t stim_q[$];
  xfer_t exp_q[$];
  obs_t  obs_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    ws_sel   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    ahb_sram_slave_if bus_if ();
    assign bus_if.S_ADDRESS     = t_addr;
    assign bus_if.S_CHIP_SELECT = t_cs;
    assign bus_if.S_BYTE_ENABLE = t_be;
    assign bus_if.S_WRITE       = t_wr;
    assign bus_if.S_WDATA       = t_wdata;
    assign bus_if.S_TRANS       = t_trans;
    assign rdy_a[g]   = bus_if.S_READY;
    assign resp_a[g]  = bus_if.S_RESP;
    assign rdata_a[g] = bus_if.S_RDATA;
    ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(WS)) u_dut (
      .HCLOCK  (HCLOCK),
      .HRESETn (HRESETn),
      .bus     (bus_if)
    );
  end

  always_comb begin
    o_rdy   = rdy_a[0];
    o_resp  = resp_a[0];
    o_rdata = rdata_a[0];
    case (sel)
      2'd1: begin o_rdy = rdy_a[1]; o_resp = resp_a[1]; o_rdata = rdata_a[1]; end
      2'd2: begin o_rdy = rdy_a[2]; o_resp = resp_a[2]; o_rdata = rdata_a[2]; end
      default: ;
    endcase
  end

  initial begin
    HCLOCK = 1'b0;
    forever #5 HCLOCK = ~HCLOCK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    t_cs = 1'b0; t_trans = 2'b00; t_addr = '0; t_wr = 1'b0; t_be = 4'h0; t_wdata = '0;
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic [1:0] resp);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.be = be; x.wdata = wdata;
    x.rdata = rdata; x.resp = resp;
    x.low = (resp == RESP_ERR) ? 1 : ws_sel;
    stim_q.push_back(x);
  endtask

  // Pipelined AHB master: entered and left at posedge+1.
  task automatic pipe_run(output bit timed_out);
    xfer_t      dp;
    obs_t       o;
    bit         have_dp = 1'b0;
    bit         acc;
    int         lowc = 0;
    int         cyc = 0;
    logic [1:0] fr = 2'b00;
    timed_out = 1'b0;
    while (stim_q.size() > 0 || have_dp) begin
      if (cyc >= 300) begin timed_out = 1'b1; break; end
      if (stim_q.size() > 0) begin
        t_cs = 1'b1; t_trans = 2'b10; t_addr = stim_q[0].addr;
        t_wr = stim_q[0].wr; t_be = stim_q[0].be;
      end else begin
        t_cs = 1'b0; t_trans = 2'b00; t_addr = '0; t_wr = 1'b0; t_be = 4'h0;
      end
      t_wdata = have_dp ? dp.wdata : 32'h0;
      @(negedge HCLOCK);
      acc = o_rdy && (stim_q.size() > 0);
      if (have_dp) begin
        if (!o_rdy) begin
          lowc++;
          if (lowc == 1) fr = o_resp;
        end else begin
          o.rdata = o_rdata; o.resp = o_resp; o.low = lowc;
          o.first_resp = (lowc > 0) ? fr : o_resp;
          obs_q.push_back(o);
          have_dp = 1'b0;
        end
      end
      @(posedge HCLOCK); #1;
      if (acc) begin
        dp = stim_q.pop_front();
        exp_q.push_back(dp);
        have_dp = 1'b1;
        lowc = 0;
      end
      cyc++;
    end
    bus_idle();
  endtask

  task automatic test_reset();
    bus_idle();
    HRESETn = 1'b0;
    sel = 2'd0;
    #23;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (rdy_a[g] !== 1'b1 || resp_a[g] !== RESP_OKAY || rdata_a[g] !== 32'h0)
        $display("FAIL reset_outputs dut%0d: got ready=%b resp=%b rdata=%h, want 1/00/0",
                 g, rdy_a[g], resp_a[g], rdata_a[g]);
      else n_pass++;
    end
    @(negedge HCLOCK);
    HRESETn = 1'b1;
    @(posedge HCLOCK); #1;
  endtask

  task automatic test_back_to_back();
    bit to;
    xfer_t e; obs_t o;
    sel = 2'd0; ws_sel = 0;
    add(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, RESP_OKAY);
    add(1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, RESP_OKAY);
    add(1'b1, 32'h0000_0014, 4'hF, 32'h0102_0304, 32'h0, RESP_OKAY);
    add(1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'h0102_0304, RESP_OKAY);
    add(1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, RESP_OKAY);
    pipe_run(to);
    n_checks++;
    if (to) $display("FAIL b2b_timeout: got timeout, want all transfers complete");
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.resp !== e.resp || o.low != e.low || o.rdata !== e.rdata)
        $display("FAIL b2b addr=%h: got rdata=%h resp=%b low=%0d, want rdata=%h resp=%b low=%0d",
                 e.addr, o.rdata, o.resp, o.low, e.rdata, e.resp, e.low);
      else n_pass++;
    end
  endtask

  task automatic test_byte_lanes();
    bit to;
    xfer_t e; obs_t o;
    sel = 2'd0; ws_sel = 0;
    add(1'b1, 32'h0000_0020, 4'hF,    32'h1122_3344, 32'h0, RESP_OKAY);
    add(1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 32'h0, RESP_OKAY);
    add(1'b0, 32'h0000_0020, 4'hF,    32'h0,         32'h11BB_33DD, RESP_OKAY);
    add(1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 32'h0, RESP_OKAY);
    add(1'b0, 32'h0000_0020, 4'hF,    32'h0,         32'h11BB_33DD, RESP_OKAY);
    add(1'b1, 32'h0000_0020, 4'b1000, 32'h77FF_FFFF, 32'h0, RESP_OKAY);
    add(1'b0, 32'h0000_0020, 4'hF,    32'h0,         32'h77BB_33DD, RESP_OKAY);
    pipe_run(to);
    n_checks++;
    if (to) $display("FAIL bytes_timeout: got timeout, want all transfers complete");
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.resp !== e.resp || o.low != e.low || o.rdata !== e.rdata)
        $display("FAIL bytes addr=%h be=%b: got rdata=%h resp=%b low=%0d, want rdata=%h resp=%b low=%0d",
                 e.addr, e.be, o.rdata, o.resp, o.low, e.rdata, e.resp, e.low);
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    bit to;
    xfer_t e; obs_t o;
    sel = 2'd1; ws_sel = 3;
    add(1'b1, 32'h0000_0040, 4'hF, 32'hA5A5_0001, 32'h0, RESP_OKAY);
    add(1'b1, 32'h0000_0044, 4'hF, 32'h0000_0044, 32'h0, RESP_OKAY);
    add(1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'hA5A5_0001, RESP_OKAY);
    add(1'b0, 32'h0000_0044, 4'hF, 32'h0,         32'h0000_0044, RESP_OKAY);
    add(1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'hA5A5_0001, RESP_OKAY);
    pipe_run(to);
    n_checks++;
    if (to) $display("FAIL wait_timeout: got timeout, want all transfers complete");
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.resp !== e.resp || o.low != e.low || o.rdata !== e.rdata)
        $display("FAIL wait addr=%h: got rdata=%h resp=%b low=%0d, want rdata=%h resp=%b low=%0d",
                 e.addr, o.rdata, o.resp, o.low, e.rdata, e.resp, e.low);
      else n_pass++;
    end
  endtask

  task automatic test_range_error();
    bit to;
    xfer_t e; obs_t o;
    sel = 2'd0; ws_sel = 0;
    add(1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'h0, RESP_OKAY);
    add(1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, 32'h0, RESP_ERR);
    add(1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'hCAFE_F00D, RESP_OKAY);
    add(1'b0, 32'hF000_0000, 4'hF, 32'h0,         32'hCAFE_F00D, RESP_OKAY);
    add(1'b1, 32'h0000_0FFC, 4'hF, 32'h5A5A_5A5A, 32'h0, RESP_OKAY);
    add(1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         32'h5A5A_5A5A, RESP_OKAY);
    add(1'b0, 32'h0000_2000, 4'hF, 32'h0,         32'h0, RESP_ERR);
    add(1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'hCAFE_F00D, RESP_OKAY);
    pipe_run(to);
    n_checks++;
    if (to) $display("FAIL range_timeout: got timeout, want all transfers complete");
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.resp !== e.resp || o.low != e.low ||
          (e.resp == RESP_OKAY && o.rdata !== e.rdata) ||
          (e.resp == RESP_ERR && o.first_resp !== RESP_ERR))
        $display("FAIL range addr=%h: got rdata=%h resp=%b first=%b low=%0d, want rdata=%h resp=%b low=%0d",
                 e.addr, o.rdata, o.resp, o.first_resp, o.low, e.rdata, e.resp, e.low);
      else n_pass++;
    end
  endtask

  task automatic test_idle_busy();
    bit to;
    xfer_t e; obs_t o;
    sel = 2'd0; ws_sel = 0;
    for (int i = 0; i < 10; i++) begin
      t_cs    = (i < 8) ? 1'b1 : 1'b0;
      t_trans = (i < 4) ? 2'b01 : ((i < 8) ? 2'b00 : 2'b10);
      t_wr = 1'b1; t_addr = 32'h0; t_be = 4'hF; t_wdata = 32'hFFFF_FFFF;
      @(negedge HCLOCK);
      n_checks++;
      if (o_rdy !== 1'b1 || o_resp !== RESP_OKAY || o_rdata !== 32'h0)
        $display("FAIL idle_busy cycle%0d: got ready=%b resp=%b rdata=%h, want 1/00/0",
                 i, o_rdy, o_resp, o_rdata);
      else n_pass++;
      @(posedge HCLOCK); #1;
    end
    bus_idle();
    add(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'hCAFE_F00D, RESP_OKAY);
    pipe_run(to);
    n_checks++;
    if (to) $display("FAIL idle_busy_timeout: got timeout, want transfer complete");
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.resp !== e.resp || o.low != e.low || o.rdata !== e.rdata)
        $display("FAIL idle_busy_read: got rdata=%h resp=%b low=%0d, want rdata=%h resp=%b low=%0d",
                 o.rdata, o.resp, o.low, e.rdata, e.resp, e.low);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    xfer_t e; obs_t o;
    sel = 2'd2; ws_sel = 5;
    add(1'b1, 32'h0000_0080, 4'hF, 32'h0102_0304, 32'h0, RESP_OKAY);
    pipe_run(to);
    n_checks++;
    if (to) $display("FAIL rst_mid_preset_timeout: got timeout, want transfer complete");
    else n_pass++;
    t_cs = 1'b1; t_trans = 2'b10; t_addr = 32'h0000_0080; t_wr = 1'b1; t_be = 4'hF;
    @(posedge HCLOCK); #1;
    bus_idle();
    t_wdata = 32'h0BAD_CAFE;
    @(posedge HCLOCK); #1;
    n_checks++;
    if (o_rdy !== 1'b0)
      $display("FAIL rst_mid_waiting: got ready=%b, want 0", o_rdy);
    else n_pass++;
    #2 HRESETn = 1'b0;
    #1;
    n_checks++;
    if (o_rdy !== 1'b1 || o_resp !== RESP_OKAY || o_rdata !== 32'h0)
      $display("FAIL rst_mid_async: got ready=%b resp=%b rdata=%h, want 1/00/0",
               o_rdy, o_resp, o_rdata);
    else n_pass++;
    @(negedge HCLOCK);
    HRESETn = 1'b1;
    t_wdata = 32'h0;
    @(posedge HCLOCK); #1;
    add(1'b0, 32'h0000_0080, 4'hF, 32'h0, 32'h0102_0304, RESP_OKAY);
    pipe_run(to);
    n_checks++;
    if (to) $display("FAIL rst_mid_timeout: got timeout, want transfer complete");
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.resp !== e.resp || o.low != e.low || o.rdata !== e.rdata)
        $display("FAIL rst_mid addr=%h: got rdata=%h resp=%b low=%0d, want rdata=%h resp=%b low=%0d",
                 e.addr, o.rdata, o.resp, o.low, e.rdata, e.resp, e.low);
      else n_pass++;
    end
  endtask

  initial begin
    sel = 2'd0;
    HRESETn = 1'b0;
    bus_idle();
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_wait_states();
    test_range_error();
    test_idle_busy();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d expected / %0d observed left, want 0/0",
               exp_q.size(), obs_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
